decoder_n_seq: RTL

- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with an internal select index.
- The index is loaded directly or stepped with wrap-around.
- The one-hot output is either held (level mode) or emitted as a timed strobe (pulse mode).
- Sits between control logic and banked resources (row/bank/mux selects) as the sequenced successor of the 2-to-4 combinational decoder.

---
 rtl/decoder_n_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/decoder_n_seq.sv
// decoder_n_seq: registered SEL_W-to-2^SEL_W one-hot select with an index
// register (load/step), level or timed-strobe output, wrap flag.
//
// Ports:
//   clk, reset (sync, active-high), enable (forces outputs to 0 when low)
//   i      : select value for load
//   load   : idx <= i (wins over step)
//   step   : idx <= idx+1 mod OUT_W
//   mode   : 0 = level, 1 = pulse of PULSE_LEN cycles
//   o      : registered one-hot select (0 or onehot(idx))
//   idx    : current index register
//   busy   : pulse in progress
//   wrap   : one-cycle flag after a step from OUT_W-1 to 0
module decoder_n_seq #(
  parameter int SEL_W     = 2,
  parameter int PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SEL_W-1:0]      i,
  input  logic                  load,
  input  logic                  step,
  input  logic                  mode,
  output logic [(2**SEL_W)-1:0] o,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_len
    $error("decoder_n_seq: PULSE_LEN must be in 1..255");
  end

  if (SEL_W < 1) begin : g_bad_sel
    $error("decoder_n_seq: SEL_W must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [OUT_W-1:0] r_o;
  logic [OUT_W-1:0] w_o_nxt;
  logic [OUT_W-1:0] w_onehot;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_acc;

  // An event is only accepted while enabled.
  assign w_acc = enable & (load | step);

  // Index for the coming cycle; load has priority and drops the step.
  always_comb begin
    w_idx_nxt = r_idx;
    if (enable) begin
      if (load) begin
        w_idx_nxt = i;
      end else if (step) begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

  assign w_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << w_idx_nxt;

  always_comb begin
    w_state_nxt = IDLE;
    w_o_nxt     = '0;
    w_cnt_nxt   = '0;
    w_busy_nxt  = 1'b0;
    w_wrap_nxt  = enable & step & ~load & (r_idx == IDX_MAX);
    if (enable) begin
      if (!mode) begin
        // Level mode: output tracks the index; any pulse is abandoned.
        w_o_nxt = w_onehot;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_acc) begin
              w_state_nxt = PULSE;
              w_o_nxt     = w_onehot;
              w_cnt_nxt   = CNT_LOAD;
              w_busy_nxt  = 1'b1;
            end
          end
          PULSE: begin
            if (w_acc) begin
              // Retrigger with no gap cycle.
              w_state_nxt = PULSE;
              w_o_nxt     = w_onehot;
              w_cnt_nxt   = CNT_LOAD;
              w_busy_nxt  = 1'b1;
            end else if (r_cnt != 8'd0) begin
              w_state_nxt = PULSE;
              w_o_nxt     = r_o;
              w_cnt_nxt   = r_cnt - 8'd1;
              w_busy_nxt  = 1'b1;
            end
          end
          default: begin
            w_state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_o     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_o     <= w_o_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign o    = r_o;
  assign idx  = r_idx;
  assign busy = r_busy;
  assign wrap = r_wrap;

endmodule
